traffic_lamp_monitor: RTL



---
 rtl/traffic_lamp_monitor.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/traffic_lamp_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_lamp_monitor                                                       |
// | Decodes NS/EW lamp codes into a phase, times each phase, flags violations. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module traffic_lamp_monitor #(
    parameter int GREEN_CYCLES  = 10000,
    parameter int YELLOW_CYCLES = 1500,
    parameter int TOL           = 0,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       NS,
    input  logic [3:0]       EW,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic             phase_done,
    output logic [CNT_W-1:0] phase_len,
    output logic [4:0]       err,
    output logic             err_any,
    output logic [15:0]      cycle_cnt
);

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        NS_G = 3'd1,
        NS_Y = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4
    } state_t;

    localparam logic [3:0] c_red = 4'b0001;
    localparam logic [3:0] c_yel = 4'b0010;
    localparam logic [3:0] c_grn = 4'b0100;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [31:0] c_green_lo  = (GREEN_CYCLES > TOL)  ? 32'(GREEN_CYCLES - TOL)  : 32'd0;
    localparam logic [31:0] c_green_hi  = 32'(GREEN_CYCLES + TOL);
    localparam logic [31:0] c_yellow_lo = (YELLOW_CYCLES > TOL) ? 32'(YELLOW_CYCLES - TOL) : 32'd0;
    localparam logic [31:0] c_yellow_hi = 32'(YELLOW_CYCLES + TOL);

    logic [3:0]       r_ns_q, r_ew_q;
    logic             r_primed;
    state_t           r_state;
    logic [CNT_W-1:0] r_dur;
    logic             r_exempt;
    logic             r_phase_done;
    logic [CNT_W-1:0] r_phase_len;
    logic [4:0]       r_err;
    logic [15:0]      r_cycle_cnt;

    logic             w_ns_red, w_ns_nonred, w_ew_red, w_ew_nonred;
    state_t           w_dec, w_succ, w_state_nx;
    logic [31:0]      w_exp_lo, w_exp_hi;
    logic [CNT_W-1:0] w_dur_nx;
    logic             w_exempt_nx, w_leave, w_wrap;
    logic             w_conflict, w_bad_code, w_bad_seq, w_short, w_long;

    always_comb begin
        w_ns_red    = (r_ns_q == c_red);
        w_ew_red    = (r_ew_q == c_red);
        w_ns_nonred = (r_ns_q == c_yel) || (r_ns_q == c_grn);
        w_ew_nonred = (r_ew_q == c_yel) || (r_ew_q == c_grn);
        w_dec = SYNC;
        if      ((r_ns_q == c_grn) && w_ew_red) w_dec = NS_G;
        else if ((r_ns_q == c_yel) && w_ew_red) w_dec = NS_Y;
        else if ((r_ew_q == c_grn) && w_ns_red) w_dec = EW_G;
        else if ((r_ew_q == c_yel) && w_ns_red) w_dec = EW_Y;
    end

    always_comb begin
        w_succ   = SYNC;
        w_exp_lo = 32'd0;
        w_exp_hi = 32'hFFFF_FFFF;
        case (r_state)
            NS_G:    begin w_succ = NS_Y; w_exp_lo = c_green_lo;  w_exp_hi = c_green_hi;  end
            NS_Y:    begin w_succ = EW_G; w_exp_lo = c_yellow_lo; w_exp_hi = c_yellow_hi; end
            EW_G:    begin w_succ = EW_Y; w_exp_lo = c_green_lo;  w_exp_hi = c_green_hi;  end
            EW_Y:    begin w_succ = NS_G; w_exp_lo = c_yellow_lo; w_exp_hi = c_yellow_hi; end
            default: ;
        endcase
    end

    // Until the input register has captured real pins after reset, nothing is decoded.
    always_comb begin
        w_state_nx  = r_state;
        w_dur_nx    = r_dur;
        w_exempt_nx = r_exempt;
        w_leave     = 1'b0;
        w_wrap      = 1'b0;
        w_conflict  = 1'b0;
        w_bad_code  = 1'b0;
        w_bad_seq   = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        if (r_primed) begin
            w_state_nx = w_dec;
            w_leave    = (r_state != SYNC) && (w_dec != r_state);
            w_short    = w_leave && !r_exempt && (32'(r_dur) < w_exp_lo);
            if (w_dec == SYNC) begin
                w_conflict  = w_ns_nonred && w_ew_nonred;
                w_bad_code  = !w_conflict;
                w_dur_nx    = '0;
                w_exempt_nx = 1'b1;
            end else if (w_dec == r_state) begin
                w_dur_nx = (r_dur == c_cnt_max) ? r_dur : r_dur + CNT_W'(1);
                w_long   = !r_exempt && (32'(w_dur_nx) > w_exp_hi) && (32'(r_dur) <= w_exp_hi);
            end else begin
                w_dur_nx = CNT_W'(1);
                if (r_state == SYNC) begin
                    w_exempt_nx = 1'b1;
                end else if (w_dec == w_succ) begin
                    w_exempt_nx = 1'b0;
                    w_wrap      = (r_state == EW_Y);
                end else begin
                    w_exempt_nx = 1'b1;
                    w_bad_seq   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= SYNC;
        else      r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ns_q       <= '0;
            r_ew_q       <= '0;
            r_primed     <= 1'b0;
            r_dur        <= '0;
            r_exempt     <= 1'b0;
            r_phase_done <= 1'b0;
            r_phase_len  <= '0;
            r_err        <= '0;
            r_cycle_cnt  <= '0;
        end else begin
            r_ns_q       <= NS;
            r_ew_q       <= EW;
            r_primed     <= 1'b1;
            r_dur        <= w_dur_nx;
            r_exempt     <= w_exempt_nx;
            r_phase_done <= w_leave;
            if (w_leave) r_phase_len <= r_dur;
            r_err        <= (clr_err ? 5'd0 : r_err)
                          | {w_long, w_short, w_bad_seq, w_bad_code, w_conflict};
            if (w_wrap) r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign phase      = r_state;
    assign phase_done = r_phase_done;
    assign phase_len  = r_phase_len;
    assign err        = r_err;
    assign err_any    = |r_err;
    assign cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire
